// File: rtl/itype_execute_pkg.sv
// itype_execute_pkg
// Shared definitions for the OP-IMM execute stage:
//   - RV32I OP-IMM opcode and funct3 encodings
//   - funct7 patterns that qualify the immediate-shift forms
//   - op-select enum produced from the decoder's one-hot enables
//   - writeback-register state enum
//   - helpers that collapse the one-hot enables and check shift immediates
package itype_execute_pkg;

    localparam logic [6:0] OPCODE_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_XORI = 3'b100;
    localparam logic [2:0] F3_SRLI = 3'b101;
    localparam logic [2:0] F3_SRAI = 3'b101;
    localparam logic [2:0] F3_ORI  = 3'b110;
    localparam logic [2:0] F3_ANDI = 3'b111;

    localparam logic [6:0] SRAI_FUNCT7  = 7'b0100000;
    localparam logic [6:0] SHIFT_FUNCT7 = 7'b0000000;

    // Enum values equal the bit positions of the enable vector
    // {andi, ori, srai, srli, xori, slli, addi}, so bit i maps to value i.
    typedef enum logic [2:0] {
        OP_ADDI = 3'd0,
        OP_SLLI = 3'd1,
        OP_XORI = 3'd2,
        OP_SRLI = 3'd3,
        OP_SRAI = 3'd4,
        OP_ORI  = 3'd5,
        OP_ANDI = 3'd6,
        OP_NONE = 3'd7
    } op_sel_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } wb_state_e;

    // Collapse the decoder's one-hot enables; anything other than exactly
    // one set bit becomes OP_NONE, which the stage treats as illegal.
    function automatic op_sel_e decode_onehot(input logic [6:0] en);
        op_sel_e    op;
        logic [2:0] cnt;
        op  = OP_NONE;
        cnt = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (en[i]) begin
                cnt = cnt + 3'd1;
                op  = op_sel_e'(i[2:0]);
            end
        end
        if (cnt != 3'd1) begin
            op = OP_NONE;
        end
        return op;
    endfunction

    // Immediate shifts reuse imm[11:5] as funct7; only the two RV32I
    // patterns are legal, and only for their matching shift kind.
    function automatic logic shift_imm_ok(input op_sel_e op, input logic [6:0] funct7);
        logic ok;
        case (op)
            OP_SLLI, OP_SRLI: ok = (funct7 == SHIFT_FUNCT7);
            OP_SRAI:          ok = (funct7 == SRAI_FUNCT7);
            default:          ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/itype_regfile.sv
// itype_regfile
// Architectural register file: NREGS x XLEN, one synchronous write port,
// two combinational read ports. Register 0 reads as zero and ignores writes.
// The whole array clears on reset, so it is built from flops, not RAM.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   we, waddr, wdata  write port (rising edge)
//   raddr_a, rdata_a  combinational read port A (operand)
//   raddr_b, rdata_b  combinational read port B (debug)
module itype_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] r_regs [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : r_regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : r_regs[raddr_b];

endmodule

// File: rtl/itype_execute.sv
// itype_execute
// Single-stage execute for RV32I OP-IMM instructions with a one-entry
// writeback (WB) register in front of the register file.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   in_valid / in_ready           op handshake; in_ready = !out_valid || out_ready
//   addi_en..andi_en              one-hot op select from the decoder
//   rs1, rd, imm                  source index, destination index, raw immediate
//   rd_en, wr_en                  read rs1 enable, writeback enable
//   out_valid / out_ready         WB register handshake; regfile written on it
//   out_rd, out_data              WB register contents
//   err                           one-cycle pulse after an illegal op is accepted
//   dbg_addr, dbg_data            combinational register-file peek
module itype_execute
    import itype_execute_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            addi_en,
    input  logic            slli_en,
    input  logic            xori_en,
    input  logic            srli_en,
    input  logic            srai_en,
    input  logic            ori_en,
    input  logic            andi_en,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rd,
    input  logic [11:0]     imm,
    input  logic            rd_en,
    input  logic            wr_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_data,
    output logic            err,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    wb_state_e               r_state;
    wb_state_e               w_state_next;
    logic [4:0]              r_out_rd;
    logic [XLEN-1:0]         r_out_data;
    logic                    r_err;

    logic [6:0]              w_en_vec;
    op_sel_e                 w_op;
    logic                    w_illegal;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_wb_fire;
    logic [XLEN-1:0]         w_rf_rs1;
    logic [XLEN-1:0]         w_operand;
    logic [XLEN-1:0]         w_imm_sext;
    logic [4:0]              w_shamt;
    logic signed [XLEN-1:0]  w_sra;
    logic [XLEN-1:0]         w_result;

    // ------------------------------------------------------------------
    // Register file: written from the WB register on its handshake.
    // ------------------------------------------------------------------
    itype_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (5)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (w_wb_fire),
        .waddr   (r_out_rd),
        .wdata   (r_out_data),
        .raddr_a (rs1),
        .rdata_a (w_rf_rs1),
        .raddr_b (dbg_addr),
        .rdata_b (dbg_data)
    );

    // ------------------------------------------------------------------
    // Decode and legality
    // ------------------------------------------------------------------
    assign w_en_vec  = {andi_en, ori_en, srai_en, srli_en, xori_en, slli_en, addi_en};
    assign w_op      = decode_onehot(w_en_vec);
    assign w_illegal = (w_op == OP_NONE) || !shift_imm_ok(w_op, imm[11:5]);

    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_wb_fire = out_valid && out_ready;
    assign w_load    = w_accept && !w_illegal && wr_en && (rd != 5'd0);

    // ------------------------------------------------------------------
    // Operand select. The pending WB value has not reached the regfile
    // yet (it lands on the same edge this op is accepted), so forward it.
    // ------------------------------------------------------------------
    always_comb begin
        w_operand = '0;
        if (rd_en) begin
            if (out_valid && (r_out_rd == rs1) && (rs1 != 5'd0)) begin
                w_operand = r_out_data;
            end else begin
                w_operand = w_rf_rs1;
            end
        end
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    assign w_imm_sext = {{(XLEN-12){imm[11]}}, imm};
    assign w_shamt    = imm[4:0];
    assign w_sra      = $signed(w_operand) >>> w_shamt;

    always_comb begin
        w_result = '0;
        case (w_op)
            OP_ADDI: w_result = w_operand + w_imm_sext;
            OP_SLLI: w_result = w_operand << w_shamt;
            OP_XORI: w_result = w_operand ^ w_imm_sext;
            OP_SRLI: w_result = w_operand >> w_shamt;
            OP_SRAI: w_result = w_sra;
            OP_ORI:  w_result = w_operand | w_imm_sext;
            OP_ANDI: w_result = w_operand & w_imm_sext;
            default: w_result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // WB register occupancy FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_load) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                // A reload on the handshake edge keeps the slot occupied.
                if (w_load) begin
                    w_state_next = ST_FULL;
                end else if (out_ready) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (r_state == ST_FULL);
    end

    // ------------------------------------------------------------------
    // WB payload and error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_rd   <= '0;
            r_out_data <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_accept && w_illegal;
            if (w_load) begin
                r_out_rd   <= rd;
                r_out_data <= w_result;
            end
        end
    end

    assign out_rd   = r_out_rd;
    assign out_data = r_out_data;
    assign err      = r_err;

endmodule
